// File: rtl/turtle_fpga_pkg.sv
// rtl/turtle_fpga_pkg.sv - shared seven-segment types, constants and hex decoder
// Contents:
//   seg7_t        7-bit cathode vector, active-low, bit 0 = segment a ... bit 6 = segment g
//   SEG_BLANK     all cathodes off
//   AN_OFF        all anodes off
//   scan_state_e  digit scan phase: BLANK (all dark) or DRIVE (one digit lit)
//   hex2seg()     nibble -> active-low segment pattern
package turtle_fpga_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t      SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  function automatic seg7_t hex2seg(input logic [3:0] nib);
    seg7_t seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_scan_controller_if.sv
// rtl/sevenseg_scan_controller_if.sv - value handshake between producer and scan controller
// Signals:
//   value_i        16  hex value offered; [3:0] -> rightmost digit, [15:12] -> leftmost
//   value_valid_i  1   value_i is offered this cycle
//   value_ready_o  1   controller's pending register is empty; transfer on valid & ready
// Modports:
//   master  producer side (drives value/valid, observes ready)
//   slave   controller side
interface sevenseg_scan_controller_if;

  logic [15:0] value_i;
  logic        value_valid_i;
  logic        value_ready_o;

  modport master (
    output value_i,
    output value_valid_i,
    input  value_ready_o
  );

  modport slave (
    input  value_i,
    input  value_valid_i,
    output value_ready_o
  );

endinterface

// File: rtl/sevenseg_scan_controller.sv
// rtl/sevenseg_scan_controller.sv - 4-digit common-anode seven-segment scanner with tear-free update
// Ports:
//   clk           in   1   system clock
//   reset_n       in   1   asynchronous active-low reset
//   val_if        slave    value/valid/ready handshake into the pending register
//   digit_en_i    in   4   per-digit enable; 0 keeps that digit dark during its slot
//   seg           out  7   cathodes, active-low, seg[0]=a ... seg[6]=g
//   an            out  4   anodes, active-low, an[0] = rightmost digit
//   frame_done_o  out  1   one-cycle pulse the cycle after each frame boundary
module sevenseg_scan_controller
  import turtle_fpga_pkg::*;
#(
  parameter int REFRESH_CYCLES = 200_000,
  parameter int BLANK_CYCLES   = 1_000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  sevenseg_scan_controller_if.slave  val_if,
  input  logic [3:0]                 digit_en_i,
  output seg7_t                      seg,
  output logic [3:0]                 an,
  output logic                       frame_done_o
);

  if (REFRESH_CYCLES < 2) begin : g_bad_refresh
    $error("sevenseg_scan_controller: REFRESH_CYCLES must be >= 2");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("sevenseg_scan_controller: BLANK_CYCLES must be >= 1");
  end

  localparam int MAX_DWELL = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  // MAX_DWELL >= 2 whenever the parameters are legal; the guard only keeps
  // the width positive while the elaboration error above is being reported.
  localparam int CNT_W = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;

  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);

  scan_state_e      state_q, state_d;
  logic [1:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      display_q, display_d;
  logic [15:0]      pending_q, pending_d;
  logic             pending_valid_q, pending_valid_d;
  seg7_t            seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             frame_done_q, frame_done_d;

  logic             dwell_done;
  logic             frame_boundary;
  logic             lit;
  logic             take_value;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= BLANK;
      digit_q         <= 2'd0;
      cnt_q           <= '0;
      display_q       <= 16'h0000;
      pending_q       <= 16'h0000;
      pending_valid_q <= 1'b0;
      seg_q           <= SEG_BLANK;
      an_q            <= AN_OFF;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      digit_q         <= digit_d;
      cnt_q           <= cnt_d;
      display_q       <= display_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      seg_q           <= seg_d;
      an_q            <= an_d;
      frame_done_q    <= frame_done_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    digit_d         = digit_q;
    cnt_d           = cnt_q;
    display_d       = display_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    seg_d           = SEG_BLANK;
    an_d            = AN_OFF;
    frame_done_d    = 1'b0;
    lit             = 1'b0;
    take_value      = 1'b0;

    // Scan sequencing: timing depends only on the dwell counter, never on
    // the digit enables, so disabled digits still consume their slot.
    dwell_done     = (state_q == BLANK) ? (cnt_q == BLANK_LAST) : (cnt_q == REFRESH_LAST);
    frame_boundary = (state_q == DRIVE) && (digit_q == 2'd3) && dwell_done;

    if (dwell_done) begin
      cnt_d = '0;
      case (state_q)
        BLANK: state_d = DRIVE;
        default: begin
          state_d = BLANK;
          digit_d = digit_q + 2'd1;
        end
      endcase
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Ready is !pending_valid_q, so a boundary promotion and a capture can
    // never both fire: a value captured on the boundary cycle waits a frame.
    take_value = val_if.value_valid_i && !pending_valid_q;
    if (frame_boundary && pending_valid_q) begin
      display_d       = pending_q;
      pending_valid_d = 1'b0;
    end else if (take_value) begin
      pending_d       = val_if.value_i;
      pending_valid_d = 1'b1;
    end

    // Pin outputs are registered: they show the state of the previous cycle.
    lit = (state_q == DRIVE) && digit_en_i[digit_q];
    if (lit) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = hex2seg(display_q[{digit_q, 2'b00} +: 4]);
    end

    frame_done_d = frame_boundary;
  end

  assign val_if.value_ready_o = !pending_valid_q;
  assign seg                  = seg_q;
  assign an                   = an_q;
  assign frame_done_o         = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_controller.sv
// tb/tb_sevenseg_scan_controller.sv - self-checking bench for sevenseg_scan_controller
module tb_sevenseg_scan_controller;

  localparam int R     = 8;
  localparam int B     = 2;
  localparam int SLOT  = R + B;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] digit_en;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_done;

  sevenseg_scan_controller_if vif ();

  sevenseg_scan_controller #(
    .REFRESH_CYCLES(R),
    .BLANK_CYCLES  (B)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .val_if      (vif),
    .digit_en_i  (digit_en),
    .seg         (seg),
    .an          (an),
    .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: scan position is pure arithmetic on the number of
  // clock edges since reset release; the pending register is a 1-deep queue.
  int          tick;
  logic [15:0] m_disp;
  logic [15:0] m_pend[$];
  logic [6:0]  seg_tab[16];

  typedef struct {
    int         n;
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h tick=%0d", name, act, exp, tick);
    end
  endtask

  task automatic model_reset();
    tick   = 0;
    m_disp = 16'h0000;
    m_pend.delete();
  endtask

  task automatic step();
    int         pos;
    int         dg;
    int         r;
    logic       lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_fd;
    pos   = tick % FRAME;
    dg    = pos / SLOT;
    r     = pos % SLOT;
    lit   = (r >= B) && digit_en[dg];
    e_an  = 4'hF;
    e_seg = 7'h7F;
    if (lit) begin
      e_an[dg] = 1'b0;
      e_seg    = seg_tab[m_disp[dg*4 +: 4]];
    end
    e_fd = (pos == FRAME - 1);
    if (e_fd && m_pend.size() != 0) m_disp = m_pend.pop_front();
    else if (vif.value_valid_i && m_pend.size() == 0) m_pend.push_back(vif.value_i);
    tick++;
    @(posedge clk);
    @(negedge clk);
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("frame_done", frame_done, e_fd);
    chk("ready", vif.value_ready_o, m_pend.size() == 0);
  endtask

  task automatic run_to_pos(input int p);
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (tick % FRAME == p) break;
    end
  endtask

  task automatic chk_pins(input string name, input logic [3:0] e_an, input logic [6:0] e_seg);
    chk({name, "_an"}, an, e_an);
    chk({name, "_seg"}, seg, e_seg);
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0]  = '{0,  4'hF, 7'h7F, 1'b0};
    vecs[1]  = '{2,  4'hF, 7'h7F, 1'b0};
    vecs[2]  = '{3,  4'hE, 7'h40, 1'b0};
    vecs[3]  = '{10, 4'hE, 7'h40, 1'b0};
    vecs[4]  = '{11, 4'hF, 7'h7F, 1'b0};
    vecs[5]  = '{12, 4'hF, 7'h7F, 1'b0};
    vecs[6]  = '{13, 4'hD, 7'h40, 1'b0};
    vecs[7]  = '{23, 4'hB, 7'h40, 1'b0};
    vecs[8]  = '{33, 4'h7, 7'h40, 1'b0};
    vecs[9]  = '{40, 4'h7, 7'h40, 1'b1};
    vecs[10] = '{41, 4'hF, 7'h7F, 1'b0};
    vecs[11] = '{80, 4'h7, 7'h40, 1'b1};

    reset_n           = 1'b0;
    digit_en          = 4'hF;
    vif.value_i       = 16'h0000;
    vif.value_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_ready", vif.value_ready_o, 1'b1);

    // Scenario 1: fixed scan timeline from reset, table-driven.
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].n == tick) begin
        chk("tab_an", an, vecs[i].an);
        chk("tab_seg", seg, vecs[i].seg);
        chk("tab_fd", frame_done, vecs[i].fd);
      end
    end
    for (int n = 1; n <= 81; n++) begin
      step();
      for (int i = 0; i < 12; i++) begin
        if (vecs[i].n == tick) begin
          chk("tab_an", an, vecs[i].an);
          chk("tab_seg", seg, vecs[i].seg);
          chk("tab_fd", frame_done, vecs[i].fd);
        end
      end
    end

    // Scenario 2: single offer right after a frame_done pulse.
    run_to_pos(0);
    chk("s2_fd_pulse", frame_done, 1'b1);
    vif.value_i       = 16'h1A3F;
    vif.value_valid_i = 1'b1;
    step();
    vif.value_valid_i = 1'b0;
    chk("s2_ready_low", vif.value_ready_o, 1'b0);
    run_to_pos(3);
    chk_pins("s2_old", 4'hE, 7'h40);
    run_to_pos(0);
    chk("s2_ready_back", vif.value_ready_o, 1'b1);
    run_to_pos(3);
    chk_pins("s2_d0", 4'hE, 7'h0E);
    run_to_pos(13);
    chk_pins("s2_d1", 4'hD, 7'h30);
    run_to_pos(23);
    chk_pins("s2_d2", 4'hB, 7'h08);
    run_to_pos(33);
    chk_pins("s2_d3", 4'h7, 7'h79);

    // Scenario 3: back-to-back offers, second held while ready is low.
    run_to_pos(1);
    vif.value_i       = 16'h1111;
    vif.value_valid_i = 1'b1;
    step();
    vif.value_i = 16'h2222;
    run_to_pos(3);
    chk_pins("s3_still_old", 4'hE, 7'h0E);
    run_to_pos(3);
    chk_pins("s3_1111", 4'hE, 7'h79);
    vif.value_valid_i = 1'b0;
    run_to_pos(3);
    chk_pins("s3_2222", 4'hE, 7'h24);

    // Scenario 4: offer on the exact frame-boundary cycle.
    run_to_pos(FRAME - 1);
    vif.value_i       = 16'h8888;
    vif.value_valid_i = 1'b1;
    step();
    vif.value_valid_i = 1'b0;
    run_to_pos(3);
    chk_pins("s4_not_yet", 4'hE, 7'h24);
    run_to_pos(3);
    chk_pins("s4_shown", 4'hE, 7'h00);

    // Scenario 5: digits 1 and 3 disabled; slot timing unchanged.
    digit_en = 4'b0101;
    run_to_pos(13);
    chk_pins("s5_d1_dark", 4'hF, 7'h7F);
    run_to_pos(23);
    chk_pins("s5_d2_lit", 4'hB, 7'h00);
    run_to_pos(33);
    chk_pins("s5_d3_dark", 4'hF, 7'h7F);
    run_to_pos(0);
    chk("s5_fd", frame_done, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if (!vif.value_valid_i || m_pend.size() == 0 || $urandom_range(0, 7) == 0) begin
        vif.value_i       = 16'($urandom);
        vif.value_valid_i = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      step();
    end

    // Scenario 6: asynchronous reset mid-DRIVE with the pending register full.
    digit_en          = 4'hF;
    vif.value_valid_i = 1'b0;
    run_to_pos(1);
    if (m_pend.size() != 0) run_to_pos(1);
    vif.value_i       = 16'hABCD;
    vif.value_valid_i = 1'b1;
    step();
    vif.value_valid_i = 1'b0;
    run_to_pos(15);
    chk("s6_pending_full", vif.value_ready_o, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s6_async_an", an, 4'hF);
    chk("s6_async_seg", seg, 7'h7F);
    chk("s6_async_ready", vif.value_ready_o, 1'b1);
    chk("s6_async_fd", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    run_to_pos(2);
    chk_pins("s6_still_blank", 4'hF, 7'h7F);
    step();
    chk_pins("s6_first_lit", 4'hE, 7'h40);
    run_to_pos(0);
    run_to_pos(3);
    chk_pins("s6_pending_lost", 4'hE, 7'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
